bandai2003_unlock_host: RTL

Console-side initiator for the Bandai 2003 cartridge unlock handshake. On request it presents the two-step address key sequence to the cartridge mapper and then receives the 18-bit synchronous serial reply on the cartridge SO line. It deframes the reply, checks it against the expected system-control code, and reports the result. On success it sets the sticky SYSTEM_CTRL1 bit-7 flag. It sits in the console bus model between the address driver and the system-control register file.

---
 rtl/bandai2003_pkg.sv | 26 ++
 rtl/bandai2003_sin.sv | 63 ++++++
 rtl/bandai2003_unlock_host.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bandai2003_pkg.sv
// rtl/bandai2003_pkg.sv - shared constants and enums for the Bandai 2003 unlock host
package bandai2003_pkg;

    localparam logic [7:0]  KEY_ACK     = 8'h5A;
    localparam logic [7:0]  KEY_NAK     = 8'hA5;
    localparam logic [7:0]  ADDR_NIH    = 8'hFF;
    localparam logic [15:0] UNLOCK_CODE = 16'h28A0;
    localparam int          FRAME_LEN   = 18;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_FRAMING = 2'd2,
        ERR_PAYLOAD = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_KEY0       = 3'd1,
        ST_KEY1       = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_DATA       = 3'd4,
        ST_STOP       = 3'd5
    } state_e;

endpackage

// File: rtl/bandai2003_sin.sv
// rtl/bandai2003_sin.sv - serial reply deframer: start detect, LSB-first shift, stop check
module bandai2003_sin
    import bandai2003_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        hunt,
    input  logic        shift,
    input  logic        stop,
    input  logic        si,
    output logic        start_det,
    output logic        data_last,
    output logic        valid,
    output logic        framing_err,
    output logic [15:0] data
);

    logic [3:0]  cnt_q, cnt_d;
    logic        full_q, full_d;
    logic [15:0] data_q, data_d;

    assign start_det   = hunt & ~si;
    assign data_last   = shift & ~full_q & (cnt_q == 4'hF);
    assign valid       = stop & ~si;
    assign framing_err = stop & si;
    assign data        = data_q;

    // full_q freezes the shifter once 16 bits are in, so the counter never wraps
    always_comb begin
        cnt_d  = cnt_q;
        full_d = full_q;
        data_d = data_q;
        if (clr) begin
            cnt_d  = 4'd0;
            full_d = 1'b0;
            data_d = 16'h0000;
        end else if (start_det) begin
            cnt_d  = 4'd0;
            full_d = 1'b0;
        end else if (shift && !full_q) begin
            data_d = {si, data_q[15:1]};
            if (cnt_q == 4'hF) begin
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 4'd0;
            full_q <= 1'b0;
            data_q <= 16'h0000;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/bandai2003_unlock_host.sv
// rtl/bandai2003_unlock_host.sv - unlock handshake initiator: key sequence, reply check, ctrl flag
module bandai2003_unlock_host
    import bandai2003_pkg::*;
#(
    parameter int          TIMEOUT = 8,
    parameter logic [15:0] EXPECT  = UNLOCK_CODE
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        start,
    input  logic        SI,
    output logic [7:0]  ADDR_O,
    output logic        ADDR_OE,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic [1:0]  err,
    output logic [15:0] code,
    output logic        ctrl_b7
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    addr_q, addr_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ok_q, ok_d;
    err_e          err_q, err_d;
    logic          ctrl_q, ctrl_d;
    logic          clr;
    logic          start_det, data_last, valid, framing_err;
    logic [15:0]   rx_data;

    bandai2003_sin u_sin (
        .clk         (CLK),
        .rst_n       (RSTn),
        .clr         (clr),
        .hunt        (state_q == ST_WAIT_START),
        .shift       (state_q == ST_DATA),
        .stop        (state_q == ST_STOP),
        .si          (SI),
        .start_det   (start_det),
        .data_last   (data_last),
        .valid       (valid),
        .framing_err (framing_err),
        .data        (rx_data)
    );

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        ok_d    = ok_q;
        err_d   = err_q;
        ctrl_d  = ctrl_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_KEY0;
                    ok_d    = 1'b0;
                    err_d   = ERR_NONE;
                    clr     = 1'b1;
                end
            end
            ST_KEY0: state_d = ST_KEY1;
            ST_KEY1: begin
                state_d = ST_WAIT_START;
                tcnt_d  = '0;
            end
            ST_WAIT_START: begin
                if (start_det) begin
                    state_d = ST_DATA;
                end else if (tcnt_q == TW'(TIMEOUT)) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_TIMEOUT;
                    done_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (data_last) state_d = ST_STOP;
            end
            ST_STOP: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (framing_err) begin
                    err_d = ERR_FRAMING;
                end else if (valid && rx_data != EXPECT) begin
                    err_d = ERR_PAYLOAD;
                end else begin
                    ok_d   = 1'b1;
                    ctrl_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus-facing outputs are registered from the next state so they line up with it
    always_comb begin
        case (state_d)
            ST_KEY0: addr_d = KEY_ACK;
            ST_KEY1: addr_d = KEY_NAK;
            default: addr_d = ADDR_NIH;
        endcase
        oe_d   = (state_d != ST_IDLE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            addr_q  <= ADDR_NIH;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= ERR_NONE;
            ctrl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            addr_q  <= addr_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ADDR_O  = addr_q;
    assign ADDR_OE = oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ok      = ok_q;
    assign err     = err_q;
    assign code    = rx_data;
    assign ctrl_b7 = ctrl_q;

endmodule
